// File: rtl/data_mem_io.sv
// data_mem_io: CPU data-port responder (word RAM + memory-mapped board I/O); optional timer under DMEM_TIMER_EN.
// Latency: reads are combinational (0 cycles); writes take effect on the rising clock edge.
// Backpressure: none, every access completes in the cycle it is presented.
module data_mem_io #(
    parameter int DEPTH_LOG2 = 5,
    parameter int SW_W       = 10,
    parameter int KEY_W      = 4,
    parameter int LED_W      = 10
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [31:0]       addr,
    input  logic [31:0]       datain,
    input  logic              we,
    output logic [31:0]       dataout,
    input  logic [SW_W-1:0]   sw,
    input  logic [KEY_W-1:0]  key,
    output logic [LED_W-1:0]  led,
    output logic [31:0]       hex
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [5:0] OFF_SW  = 6'd0;
    localparam logic [5:0] OFF_KEY = 6'd1;
    localparam logic [5:0] OFF_LED = 6'd2;
    localparam logic [5:0] OFF_HEX = 6'd3;
    localparam logic [5:0] OFF_TMR = 6'd4;

    logic                  io_sel;
    logic [5:0]            reg_off;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  ram_wr;
    logic                  io_wr;
    logic [KEY_W-1:0]      key_clr;
    logic [KEY_W-1:0]      key_press;
    logic [31:0]           io_rdat;

    logic [31:0]           mem [DEPTH];
    logic [SW_W-1:0]       sw_s1, sw_s2;
    logic [KEY_W-1:0]      k1, k2, k3;
    logic [KEY_W-1:0]      key_flag;
    logic [31:0]           tmr_cnt;

    // Address bits that select neither a RAM word nor an I/O register.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[11:8], addr[1:0]};

    assign io_sel  = (addr[31:12] == 20'hFFFFF);
    assign reg_off = addr[7:2];
    assign ram_idx = addr[DEPTH_LOG2+1:2];
    assign ram_wr  = we & ~io_sel;
    assign io_wr   = we & io_sel;

    assign key_clr   = (io_wr && reg_off == OFF_KEY) ? datain[KEY_W-1:0] : '0;
    assign key_press = k3 & ~k2;

    // RAM has no reset term: a store still lands while resetn is low.
    always_ff @(posedge clock) begin
        if (ram_wr) begin
            mem[ram_idx] <= datain;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    // Keys idle high; a press is a falling edge seen one stage down the chain,
    // so a held key raises its flag exactly once. Set wins over clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            k1       <= '1;
            k2       <= '1;
            k3       <= '1;
            key_flag <= '0;
        end else begin
            k1       <= key;
            k2       <= k1;
            k3       <= k2;
            key_flag <= (key_flag & ~key_clr) | key_press;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            led <= '0;
            hex <= '0;
        end else begin
            if (io_wr && reg_off == OFF_LED) begin
                led <= datain[LED_W-1:0];
            end
            if (io_wr && reg_off == OFF_HEX) begin
                hex <= datain;
            end
        end
    end

`ifdef DMEM_TIMER_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmr_cnt <= '0;
        end else if (io_wr && reg_off == OFF_TMR) begin
            tmr_cnt <= datain;
        end else begin
            tmr_cnt <= tmr_cnt + 32'd1;
        end
    end
`else
    assign tmr_cnt = '0;
`endif

    always_comb begin
        io_rdat = '0;
        case (reg_off)
            OFF_SW:  io_rdat[SW_W-1:0]  = sw_s2;
            OFF_KEY: io_rdat[KEY_W-1:0] = key_flag;
            OFF_LED: io_rdat[LED_W-1:0] = led;
            OFF_HEX: io_rdat            = hex;
            OFF_TMR: io_rdat            = tmr_cnt;
            default: io_rdat            = '0;
        endcase
        dataout = io_sel ? io_rdat : mem[ram_idx];
    end

endmodule

// File: tb/tb_data_mem_io.sv
// Bench for data_mem_io: directed test-plan steps followed by a randomized phase, all
// checked against an abstract model (RAM array, register values, input sample history).
module tb_data_mem_io;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [9:0]  led;
    logic [31:0] hex;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_io #(.DEPTH_LOG2(5), .SW_W(10), .KEY_W(4), .LED_W(10)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .addr    (addr),
        .datain  (datain),
        .we      (we),
        .dataout (dataout),
        .sw      (sw),
        .key     (key),
        .led     (led),
        .hex     (hex)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [31:0] ram_m [0:31];
    logic [9:0]  led_m;
    logic [31:0] hex_m;
    logic [31:0] tmr_m;
    logic [3:0]  flag_m;
    logic [9:0]  sw_prev, sw_vis;      // switch samples at the last edge / visible value
    logic [3:0]  kh1, kh2, kh3;        // key samples at the last three edges, newest first

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a[31:12] == 20'hFFFFF) begin
            case (a[7:2])
                6'd0: r = {22'h0, sw_vis};
                6'd1: r = {28'h0, flag_m};
                6'd2: r = {22'h0, led_m};
                6'd3: r = hex_m;
`ifdef DMEM_TIMER_EN
                6'd4: r = tmr_m;
`endif
                default: r = 32'h0;
            endcase
        end else begin
            r = ram_m[a[6:2]];
        end
        return r;
    endfunction

    task automatic model_reset();
        led_m   = '0;
        hex_m   = '0;
        tmr_m   = '0;
        flag_m  = '0;
        sw_prev = '0;
        sw_vis  = '0;
        kh1     = '1;
        kh2     = '1;
        kh3     = '1;
    endtask

    // Effect of one rising edge given the inputs currently applied.
    task automatic model_edge();
        logic       io;
        logic [5:0] off;
        logic [3:0] clr;
        logic [3:0] press;
        io  = (addr[31:12] == 20'hFFFFF);
        off = addr[7:2];
        if (we && !io) ram_m[addr[6:2]] = datain;
        if (!resetn) begin
            model_reset();
        end else begin
            // key low at an edge, high the edge before -> flag set two edges later
            press  = kh3 & ~kh2;
            clr    = (we && io && off == 6'd1) ? datain[3:0] : 4'h0;
            flag_m = (flag_m & ~clr) | press;
            kh3 = kh2; kh2 = kh1; kh1 = key;
            sw_vis  = sw_prev;
            sw_prev = sw;
            if (we && io && off == 6'd2) led_m = datain[9:0];
            if (we && io && off == 6'd3) hex_m = datain;
            tmr_m = (we && io && off == 6'd4) ? datain : tmr_m + 32'd1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #2;
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        we   = 1'b0;
        addr = a;
        #1;
        check(tag, dataout, model_read(a));
    endtask

    task automatic rdc(input logic [31:0] a, input logic [31:0] exp, input string tag);
        we   = 1'b0;
        addr = a;
        #1;
        check(tag, dataout, exp);
        check({tag, "_model"}, dataout, model_read(a));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        datain = d;
        we     = 1'b1;
        tick();
        we     = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_led"}, {22'h0, led}, {22'h0, led_m});
        check({tag, "_hex"}, hex, hex_m);
    endtask

    initial begin
        logic [31:0] a, d;
        resetn = 1'b0;
        addr   = 32'h0;
        datain = 32'h0;
        we     = 1'b0;
        sw     = 10'h3C3;
        key    = 4'hF;
        model_reset();
        #3;
        check_outs("reset");
        rdc(32'hFFFFF000, 32'h0, "reset_sw");
        rdc(32'hFFFFF004, 32'h0, "reset_key");
        rdc(32'hFFFFF010, 32'h0, "reset_tmr");
        resetn = 1'b1;
        @(posedge clock);
        #2;

        for (int i = 0; i < 32; i++) wr(i * 4, $urandom);

        // RAM write, readback and upper-bit alias
        wr(32'h14, 32'hDEADBEEF);
        rdc(32'h14, 32'hDEADBEEF, "ram_rd");
        rdc(32'h94, 32'hDEADBEEF, "ram_alias");

        // read during a write to the same word returns the old value
        wr(32'h8, 32'h1);
        addr = 32'h8; datain = 32'h2; we = 1'b1;
        #1;
        check("rd_during_wr", dataout, 32'h1);
        tick();
        rdc(32'h8, 32'h2, "rd_after_wr");

        // LED / HEX / unmapped I/O
        wr(32'hFFFFF008, 32'h000003FF);
        check("led_wr", {22'h0, led}, 32'h3FF);
        wr(32'hFFFFF00C, 32'h12345678);
        check("hex_wr", hex, 32'h12345678);
        rdc(32'hFFFFF00C, 32'h12345678, "hex_rd");
        wr(32'hFFFFF020, 32'hFFFFFFFF);
        check_outs("unmapped_wr");
        rdc(32'hFFFFF020, 32'h0, "unmapped_rd");
        rd(32'h20, "ram_untouched_by_io");

        // key press -> sticky flag after the third edge, cleared by W1C, held key sets once
        key = 4'hB;
        tick();
        tick();
        rdc(32'hFFFFF004, 32'h0, "key_after_e2");
        tick();
        rdc(32'hFFFFF004, 32'h4, "key_after_e3");
        tick();
        wr(32'hFFFFF004, 32'h4);
        rdc(32'hFFFFF004, 32'h0, "key_cleared");
        for (int i = 0; i < 5; i++) tick();
        rdc(32'hFFFFF004, 32'h0, "key_held_once");
        key = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        // press event coinciding with a clear of the same bit
        key = 4'hB;
        tick();
        tick();
        wr(32'hFFFFF004, 32'h4);
        rdc(32'hFFFFF004, 32'h4, "key_set_wins");
        wr(32'hFFFFF004, 32'hF);
        rdc(32'hFFFFF004, 32'h0, "key_clear2");
        key = 4'hF;
        tick();

        // timer
        wr(32'hFFFFF010, 32'hFFFFFFFE);
`ifdef DMEM_TIMER_EN
        rdc(32'hFFFFF010, 32'hFFFFFFFE, "tmr_load");
        tick();
        rdc(32'hFFFFF010, 32'hFFFFFFFF, "tmr_inc");
        tick();
        rdc(32'hFFFFF010, 32'h0, "tmr_wrap");
`else
        rdc(32'hFFFFF010, 32'h0, "tmr_absent");
        tick();
        rdc(32'hFFFFF010, 32'h0, "tmr_absent2");
`endif

        // asynchronous reset with state set up
        wr(32'hFFFFF008, 32'h2AA);
        wr(32'hFFFFF00C, 32'hA5A5A5A5);
        key = 4'hD;
        for (int i = 0; i < 3; i++) tick();
        sw = 10'h2A5;
        tick();
        tick();
        rdc(32'hFFFFF004, 32'h2, "pre_reset_key");
        rdc(32'hFFFFF000, 32'h2A5, "pre_reset_sw");
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_rst_led", {22'h0, led}, 32'h0);
        check("async_rst_hex", hex, 32'h0);
        rdc(32'hFFFFF004, 32'h0, "rst_key");
        rdc(32'hFFFFF000, 32'h0, "rst_sw");
        // writes across an edge in reset: I/O lost, RAM kept
        wr(32'hFFFFF008, 32'h155);
        check("rst_led_wr_lost", {22'h0, led}, 32'h0);
        wr(32'h10, 32'hCAFEF00D);
        key = 4'hF;
        #1;
        resetn = 1'b1;
        rdc(32'h10, 32'hCAFEF00D, "rst_ram_wr_kept");
        rdc(32'hFFFFF000, 32'h0, "sw_rel_e0");
        tick();
        rdc(32'hFFFFF000, 32'h0, "sw_rel_e1");
        tick();
        rdc(32'hFFFFF000, 32'h2A5, "sw_rel_e2");

        // randomized mix of RAM and I/O traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom & 32'h7FFFFFFF;
                1, 2: a = {20'hFFFFF, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 5)),
                           2'($urandom_range(0, 3))};
                default: a = {20'hFFFFF, 12'($urandom)};
            endcase
            d = $urandom;
            if ($urandom_range(0, 3) == 0) key = 4'($urandom);
            sw     = 10'($urandom);
            addr   = a;
            datain = d;
            we     = ($urandom_range(0, 1) == 1);
            #1;
            check("rand_rd", dataout, model_read(a));
            tick();
            check_outs("rand");
        end
        we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory responder for the pipelined CPU. It serves the CPU's MEM-stage port: the CPU drives the address, write data and write enable, and this block returns read data in the same cycle. The block contains a small word-addressed RAM and a memory-mapped I/O window for board switches, push-keys, LEDs, a hex-display word and an optional timer. It sits between the CPU's data port and the board pins.

## Interface
- `DEPTH_LOG2`, 5 — RAM holds 2^DEPTH_LOG2 32-bit words.
- `SW_W`, 10 — number of slide-switch inputs.
- `KEY_W`, 4 — number of push-keys; keys are active-low.
- `LED_W`, 10 — number of LED outputs.
- `clock` input 1 — the single clock; all state changes on its rising edge.
- `resetn` input 1 — asynchronous, active-low reset.
- `addr` input 32 — byte address from the CPU ALU result; bits [1:0] are ignored.
- `datain` input 32 — store data from the CPU.
- `we` input 1 — write enable (the CPU `wmem` signal).
- `dataout` output 32 — read data returned to the CPU (`mem`). Combinational from `addr`.
- `sw` input SW_W — raw, asynchronous slide-switch levels.
- `key` input KEY_W — raw, asynchronous key levels; 0 means pressed.
- `led` output LED_W — LED register.
- `hex` output 32 — hex-display word, 8 nibbles, raw; decoding is done downstream.

## Operation
- Region select:
  - I/O when `addr[31:12]` == 20'hFFFFF; register offset = `addr[7:2]`.
  - Otherwise RAM at word index `addr[DEPTH_LOG2+1:2]`. Upper bits alias.
- RAM:
  - Asynchronous read.
  - Write of `datain` on the rising edge when `we`=1 and RAM is selected.
  - Not reset; bench preloads it.
- I/O map (I/O addresses are byte addresses):
  - 0xFFFFF000 SW, read-only: synchronized switches, zero-extended.
  - 0xFFFFF004 KEY, read / write-1-to-clear: sticky press flags in [KEY_W-1:0].
  - 0xFFFFF008 LED, read/write: `datain[LED_W-1:0]`.
  - 0xFFFFF00C HEX, read/write: full 32 bits.
  - 0xFFFFF010 TIMER: see Configuration.
  - Any other I/O offset reads 0; writes are ignored.
- Switch synchronizer: two flops per bit, reset to 0.
- Key synchronizer and edge detection:
  - Chain k1→k2→k3 per bit, reset to all-ones (released).
  - Press event = `k3 & ~k2`.
  - Flag update: flag ← (flag & ~clr) | press, where clr = `datain` bits when KEY is written.
  - Set wins over clear in the same cycle.
  - A held key sets its flag once only.
- The RAM is never written by I/O-region accesses, including aliased I/O addresses.

## Timing
- Read latency is 0 cycles: `dataout` is valid combinationally within the same cycle as `addr`.
- A write at edge E is visible to a read from the cycle after E.
- A read to the address being written in the same cycle returns the old value.
- `led` and `hex` change on the edge of the write.
- Switch change to SW readback:
  - A change sampled at edge E1 is readable after edge E2.
  - Pulses shorter than one cycle may be missed.
- Key press to flag:
  - A key low at edge E1 has its flag readable after edge E3.
  - Release needs no cycles; re-arming requires k2 to be high for one edge.
- Reset, asserted asynchronously at any time:
  - `led`=0, `hex`=0.
  - Key flags = 0; key sync flops = 1; switch sync flops = 0.
  - TIMER = 0.
  - During reset, `dataout` returns these reset values for I/O reads.
- Reset in the middle of a write:
  - The write is lost if `resetn`=0 at the edge.
  - This applies to I/O registers only; the RAM has no reset term and the write still occurs.

## Configuration
- `DMEM_TIMER_EN` defined:
  - TIMER at 0xFFFFF010 is a 32-bit free-running counter; +1 every cycle, wrapping from 0xFFFFFFFF to 0.
  - A write loads `datain` at that edge, so the next cycle reads `datain`, then counting resumes.
  - A write takes priority over the increment.
- `DMEM_TIMER_EN` undefined:
  - No counter is built.
  - 0xFFFFF010 reads 0 and writes are ignored.

## Test plan
- RAM: write 0xDEADBEEF to 0x00000014, then read 0x00000014 → 0xDEADBEEF the next cycle. Read 0x00000094 with DEPTH_LOG2=5 → 0xDEADBEEF (alias).
- Same-cycle write and read: address 0x8 holds 0x1, write 0x2 to 0x8 → `dataout`=0x1 during the write cycle and 0x2 after the edge.
- LED/HEX: write 0x3FF to 0xFFFFF008 → `led`=10'h3FF after the edge. Write 0x12345678 to 0xFFFFF00C → `hex`=0x12345678 and readback matches. A write to 0xFFFFF020 changes nothing and reads back 0.
- KEY: drive `key[2]` low at edge E1 → KEY reads 0x4 after E3. Hold the key 10 cycles and clear it at E5 by writing 0x4 → reads 0 and stays 0. A press edge coinciding with a clear → flag remains 1.
- Reset: set `led`, `hex` and flags, then pulse `resetn` low between edges → outputs go to 0 immediately, without waiting for a clock edge, and SW reads 0 until two edges after release.
- Timer (`DMEM_TIMER_EN`): write 0xFFFFFFFE → reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0 on successive cycles. Without the macro → always reads 0.
